interrupt_controller: RTL

- Collects 8 external interrupt request lines, latches rising edges into a pending register and applies a software-writable mask.
- Selects the highest-priority enabled request using the team's 8-to-3 priority ordering (bit 7 highest) and presents its ID and handler vector to the CPU front end.
- Uses a req/ack/end-of-interrupt handshake.
- Sits upstream of the PC-select mux: int_vector is the mux input that int_req/int_ack steer into the fetch PC.

---
 rtl/interrupt_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// ----------------------------------------------------------------------------
// interrupt_controller
//
// This block collects eight interrupt request lines. It latches each rising
// edge into a pending register and filters the pending bits through a
// software-writable mask. It then presents the highest-priority enabled
// request (bit 7 highest) to the CPU front end as an ID and a handler vector.
// The CPU takes the request with a req/ack handshake and releases it with
// end-of-interrupt. int_vector feeds the PC-select mux.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       asynchronous, active-high reset
//   irq_in      raw interrupt request lines, synchronous to clk
//   mask_we     write strobe for the mask register
//   mask_wdata  new mask value (1 = enabled)
//   int_ack     CPU accepts the presented interrupt
//   eoi         CPU signals end of the handler in service
//   mask        current mask register
//   pending     current pending register
//   int_req     interrupt request to the CPU (high in REQ)
//   int_id      ID of the requested or in-service interrupt
//   int_vector  handler address for int_id
//   busy        high while a handler is in service
// ----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int               width        = 32,
    parameter logic [width-1:0] VECTOR_BASE  = 32'h0000_0180,
    parameter int               VECTOR_SHIFT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       irq_in,
    input  logic             mask_we,
    input  logic [7:0]       mask_wdata,
    input  logic             int_ack,
    input  logic             eoi,
    output logic [7:0]       mask,
    output logic [7:0]       pending,
    output logic             int_req,
    output logic [2:0]       int_id,
    output logic [width-1:0] int_vector,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [7:0]       irq_prev;
    logic [7:0]       rise;
    logic [7:0]       clr;
    logic [7:0]       eligible;
    logic             any;
    logic [2:0]       winner;
    logic [width-1:0] winner_vec;
    logic             load;
    logic             ack_take;

    // Each line produces one event per low-to-high transition. A line that is
    // held high does not retrigger.
    assign rise     = irq_in & ~irq_prev;
    assign eligible = pending & mask;
    // The any flag is needed because ID 0 and "no request" both encode as 0.
    assign any      = |eligible;
    assign ack_take = (state == REQ) && int_ack;
    assign clr      = ack_take ? (8'b1 << int_id) : 8'h00;

    // The scan runs upward, so the highest eligible bit is the last one
    // assigned and wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // The add wraps at the vector width.
    assign winner_vec = VECTOR_BASE + (width'(winner) << VECTOR_SHIFT);

    // NOTE: every signal driven here gets a default before the case. Without
    // the defaults, a path that does not assign a signal would infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_next = REQ;
                    load       = 1'b1;
                end
            end
            REQ: begin
                // If eoi arrives in the same cycle as the ack, it is ignored.
                if (int_ack) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the values from before the edge, and the result does not
    // depend on the order of the statements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            irq_prev   <= 8'h00;
            pending    <= 8'h00;
            mask       <= 8'h00;
            int_req    <= 1'b0;
            busy       <= 1'b0;
            int_id     <= 3'd0;
            int_vector <= VECTOR_BASE;
        end else begin
            state    <= state_next;
            irq_prev <= irq_in;
            // A new edge on the bit that is being acknowledged is a new
            // event, so the set term overrides the clear term.
            pending  <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            int_req <= (state_next == REQ);
            busy    <= (state_next == SERVICE);
            // ID and vector are captured only when leaving IDLE. They stay
            // fixed through REQ and SERVICE, so a request is never preempted.
            if (load) begin
                int_id     <= winner;
                int_vector <= winner_vec;
            end
        end
    end

endmodule
